// File: rtl/prog_fetch_seq.sv
// prog_fetch_seq: instruction-fetch sequencer for the 9-bit multicycle processor.
// Holds a loadable program memory and a PC, issues one word per processor T0,
// supplies the mvi immediate during T1, waits for Done, stops at EndAddr and
// flags a processor that never returns Done.
//
// Ports:
//   Clock, Resetn        clock (rising edge), synchronous active-low reset
//   Load/LdAddr/LdData   program memory write port (honoured when not busy, not in error)
//   EndAddr              run stops when PC >= EndAddr (latched on Start)
//   Start                begin a run from address 0
//   Done                 processor done (same-cycle)
//   DIN, Run             instruction/immediate word and Run strobe to the processor
//   PC                   program counter register
//   Busy                 high while issuing/executing
//   Finished             one-cycle completion pulse
//   Error                sticky watchdog error
module prog_fetch_seq #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned WDOG   = 4
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Load,
   input  logic [ADDR_W-1:0] LdAddr,
   input  logic [8:0]        LdData,
   input  logic [ADDR_W:0]   EndAddr,
   input  logic              Start,
   input  logic              Done,
   output logic [8:0]        DIN,
   output logic              Run,
   output logic [ADDR_W:0]   PC,
   output logic              Busy,
   output logic              Finished,
   output logic              Error
);

   localparam int unsigned DEPTH  = 2**ADDR_W;
   localparam int unsigned WORD_W = 9;
   localparam int unsigned PC_W   = ADDR_W + 1;
   localparam int unsigned WD_W   = $clog2(WDOG);
   localparam logic [2:0]  OP_MVI = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_EXEC,
      S_FINISH,
      S_ERROR
   } state_t;

   state_t            state;
   logic [PC_W-1:0]   end_q;
   logic [2:0]        op_q;
   logic [WD_W-1:0]   wd_q;
   logic [WORD_W-1:0] mem [DEPTH];

   logic              ld_en;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   pc_done;
   logic [WORD_W-1:0] rd_first;
   logic [WORD_W-1:0] rd_inc;
   logic [WORD_W-1:0] rd_done;

   // Writes are accepted only while the sequencer is quiescent (IDLE or FINISH).
   assign ld_en = Load && ((state == S_IDLE) || (state == S_FINISH));

   // PC after the current word; mvi additionally skips its immediate on Done.
   assign pc_inc  = PC + PC_W'(1);
   assign pc_done = PC + PC_W'(op_q == OP_MVI);

   // DIN is registered, so the word for the next state is read one edge early.
   // A load to address 0 in the Start cycle is forwarded so the new word is issued.
   assign rd_first = (ld_en && (LdAddr == '0)) ? LdData : mem[0];
   assign rd_inc   = mem[pc_inc[ADDR_W-1:0]];
   assign rd_done  = mem[pc_done[ADDR_W-1:0]];

   // Program memory: synchronous write, asynchronous read, not reset.
   always_ff @(posedge Clock) begin
      if (ld_en) begin
         mem[LdAddr] <= LdData;
      end
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state    <= S_IDLE;
         PC       <= '0;
         end_q    <= '0;
         op_q     <= '0;
         wd_q     <= '0;
         DIN      <= '0;
         Run      <= 1'b0;
         Busy     <= 1'b0;
         Finished <= 1'b0;
         Error    <= 1'b0;
      end else begin
         Run      <= 1'b0;
         Finished <= 1'b0;
         case (state)
            S_IDLE, S_ERROR: begin
               if (Start) begin
                  end_q <= EndAddr;
                  PC    <= '0;
                  Error <= 1'b0;
                  if (EndAddr == '0) begin
                     state    <= S_FINISH;
                     Finished <= 1'b1;
                     DIN      <= '0;
                  end else begin
                     state <= S_ISSUE;
                     Run   <= 1'b1;
                     Busy  <= 1'b1;
                     DIN   <= rd_first;
                  end
               end
            end
            S_ISSUE: begin
               op_q  <= DIN[8:6];
               PC    <= pc_inc;
               wd_q  <= '0;
               DIN   <= rd_inc;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (Done) begin
                  PC <= pc_done;
                  if (pc_done >= end_q) begin
                     state    <= S_FINISH;
                     Finished <= 1'b1;
                     Busy     <= 1'b0;
                     DIN      <= '0;
                  end else begin
                     state <= S_ISSUE;
                     Run   <= 1'b1;
                     DIN   <= rd_done;
                  end
               end else begin
                  wd_q <= wd_q + WD_W'(1);
                  // The count reaches WDOG-1 on this edge.
                  if (wd_q == WD_W'(WDOG - 2)) begin
                     state <= S_ERROR;
                     Error <= 1'b1;
                     Busy  <= 1'b0;
                     DIN   <= '0;
                  end
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               Busy  <= 1'b0;
               DIN   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/prog_fetch_seq.md
Name: prog_fetch_seq

Overview:
Instruction-fetch sequencer that sits directly upstream of the 9-bit multicycle processor and drives its DIN and Run inputs. It holds a small loadable program memory and a program counter. It issues one instruction word per processor T0 cycle, supplies the immediate word for mvi, and waits on the processor's Done before issuing the next word. It stops at a programmed end address, and a watchdog flags a processor that never returns Done.

Parameters:
ADDR_W, 5, program memory address width (2**ADDR_W words of 9 bits)
WDOG, 4, maximum consecutive EXEC cycles without Done before ERROR (must be >= 4)

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  synchronous active-low reset
Load  in  1  write LdData to mem[LdAddr] this cycle (honoured only when Busy=0)
LdAddr  in  ADDR_W  program memory write address
LdData  in  9  program memory write data
EndAddr  in  ADDR_W+1  run stops when PC >= EndAddr (sampled on Start)
Start  in  1  begin execution from address 0 (ignored while Busy=1)
Done  in  1  processor Done (combinational, same-cycle)
DIN  out  9  instruction/immediate word to processor
Run  out  1  processor Run
PC  out  ADDR_W+1  current program counter
Busy  out  1  high in ISSUE or EXEC
Finished  out  1  one-cycle pulse when the program completes
Error  out  1  sticky watchdog error flag

Behaviour:
- Single clock Clock. Reset is synchronous and active-low on Resetn: at a rising edge with Resetn=0, state=IDLE, PC=0, Run=0, DIN=0, Busy=0, Finished=0, Error=0, watchdog count=0. Memory contents are not reset.
- Memory: 2**ADDR_W x 9, synchronous write, asynchronous read. Read index is PC[ADDR_W-1:0]; PC values >= 2**ADDR_W wrap the index.
- Opcode of a word = bits [8:6]: 000 mv, 001 mvi, 010 add, 011 sub. Other codes are executed like add/sub; the sequencer only waits for Done.
- State machine:
  - IDLE: DIN=0, Run=0. On Start: latch EndAddr, PC<=0, clear Error. If the latched EndAddr==0 go to FINISH, else go to ISSUE.
  - ISSUE (processor in T0): DIN=mem[PC], Run=1. Register the word's opcode, PC<=PC+1, watchdog count<=0, go to EXEC.
  - EXEC (processor in T1..T3): Run=0, DIN=mem[PC]. DIN carries the immediate during T1 for mvi.
    - If Done=1: for mvi, PC<=PC+1 (skips the immediate). Then if the resulting PC >= the latched EndAddr go to FINISH, else go to ISSUE.
    - If Done=0: increment the watchdog count. When the count reaches WDOG-1, go to ERROR.
  - FINISH: Finished=1 for exactly this cycle, then go to IDLE.
  - ERROR: Error=1, Run=0, DIN=0. Stays in ERROR until Start, which behaves as Start from IDLE, or until reset.
- Throughput and latency:
  - mv/mvi: 2 cycles (ISSUE + 1 EXEC).
  - add/sub: 4 cycles (ISSUE + 3 EXEC).
  - Next ISSUE follows Done with no bubble, matching the processor's return to T0.
- mvi at address EndAddr-1: the immediate is still read from address EndAddr; PC ends at EndAddr+1 and the run finishes.
- Load while Busy=1 or in ERROR: ignored, memory unchanged. Load in IDLE in the same cycle as Start: the write completes and the run begins normally.
- Start while Busy=1: ignored.
- Done in ISSUE or IDLE: ignored.
- Reset in the middle of a run: the sequencer returns to IDLE next edge with Run=0. The processor shares Resetn and also returns to T0.
- Busy=1 exactly in ISSUE and EXEC. PC output reflects the register value.

Test Plan:
- Reset: hold Resetn=0 for 2 cycles mid-run -> IDLE, Run=0, DIN=0, PC=0, Busy=0, Finished=0, Error=0; a preloaded mem[0] is unchanged.
- Load {0x040,0x005,0x048,0x003,0x081,0x010}, EndAddr=6, Start, with the processor attached -> Finished pulses 10 cycles after the first ISSUE; R0=8, R1=3, R2=8; PC=6.
- Run pulse timing: with the program above, Run is high only in cycles 0, 2, 4 and 8 after Start; DIN=0x005 in cycle 1 and DIN=0x003 in cycle 3.
- Watchdog: single word 0x081, Done tied low, WDOG=4 -> ERROR entered after ISSUE + 3 EXEC cycles, Error=1 and sticky, Run=0; a subsequent Start clears Error.
- EndAddr=0, Start -> Finished pulses on the next cycle, Run never asserted, PC=0.
- mvi as the last word: mem[0]=0x040, mem[1]=0x1FF, EndAddr=1 -> DIN=0x1FF during EXEC, PC ends at 2, Finished pulses; Load and Start attempts during the run are ignored.
